// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter sitting downstream of the TX FIFO.
// Sends each byte as an 8N1 frame, LSB first, at a fixed compile-time baud rate.
// Defining UART_TX_PARITY_EN adds an even-parity bit, which makes the frame 8E1.
//
// State table:
//   state  | meaning
//   IDLE   | line high; pops the FIFO head when have_next_i is set
//   START  | start bit (0) on the line
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit (1) on the line
//
// Ports:
//   clk_i        core clock
//   reset_ni     synchronous active-low reset
//   have_next_i  FIFO not empty
//   data_i       FIFO head byte (sampled only in IDLE)
//   next_o       one-cycle pop strobe to the FIFO
//   tx_o         registered serial line, idles high
//   busy_o       frame in progress (state != IDLE)
module uart_tx #(
  parameter int unsigned ClkHz = 20_000_000,
  parameter int unsigned Baud  = 115_200,
  parameter int unsigned Div   = ClkHz / Baud
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       have_next_i,
  input  logic [7:0] data_i,
  output logic       next_o,
  output logic       tx_o,
  output logic       busy_o
);

  // Div >= 4 keeps IDLE at least 2 cycles clear of the last pop, so the FIFO's
  // one-cycle-late have_next can never cause a stale second pop.
  if (Div < 4) begin : g_div_check
    $fatal(1, "uart_tx: Div (ClkHz/Baud) must be at least 4");
  end

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic            tick;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign tick   = (baud_cnt_q == CntMax);
  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    next_o     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // The baud counter runs in every state except IDLE and wraps on each tick.
    if (state_q != IDLE) begin
      baud_cnt_d = tick ? '0 : baud_cnt_q + CntW'(1);
    end

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        tx_d       = 1'b1;
        // reset_ni is ANDed in here so next_o stays low while reset is held.
        if (have_next_i && reset_ni) begin
          next_o   = 1'b1;
          shift_d  = data_i;
          state_d  = START;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_i;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;  // wraps 7 -> 0 on the exit
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int Div = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       have_next_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       next_o;
  logic       tx_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.ClkHz(460_800), .Baud(115_200)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .have_next_i (have_next_i),
    .data_i      (data_i),
    .next_o      (next_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame slot j (0 = start bit), LSB first.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Entry: in cycle T with have_next_i=1 and data_i=b already driven.
  // Exit: inside the last stop-bit cycle.
  task automatic run_frame(input logic [7:0] b, input bit scramble);
    #1;
    chk("pop_at_T", next_o, 1'b1);
    chk("idle_at_T", busy_o, 1'b0);
    for (int i = 0; i < NBits * Div; i++) begin
      next_cycle();
      if (scramble) begin
        have_next_i = 1'b1;
        data_i = 8'($urandom);
      end else begin
        have_next_i = 1'b0;
      end
      #1;
      chk($sformatf("tx_%02h_slot%0d", b, i / Div), tx_o, exp_bit(b, i / Div));
      chk("busy_in_frame", busy_o, 1'b1);
      chk("no_pop_in_frame", next_o, 1'b0);
    end
  endtask

  initial begin
    // Reset held with have_next_i high: no pop, line high, not busy.
    reset_ni = 1'b0;
    have_next_i = 1'b1;
    data_i = 8'h99;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      chk("rst_no_pop", next_o, 1'b0);
      chk("rst_tx", tx_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
    end

    // Idle with empty FIFO.
    next_cycle();
    reset_ni = 1'b1;
    have_next_i = 1'b0;
    #1;
    chk("idle_no_pop", next_o, 1'b0);
    next_cycle();
    chk("idle_tx", tx_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);

    // Single byte 0x55, IDLE reached 41 cycles after the pop.
    have_next_i = 1'b1;
    data_i = 8'h55;
    run_frame(8'h55, 1'b0);
    next_cycle();
    have_next_i = 1'b0;
    #1;
    chk("post_55_busy", busy_o, 1'b0);
    chk("post_55_tx", tx_o, 1'b1);
    chk("post_55_no_pop", next_o, 1'b0);

    // Back-to-back 0x00, 0xFF, 0xA3: pops spaced exactly one frame + 1 apart.
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'h00;
    run_frame(8'h00, 1'b0);
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'hFF;
    run_frame(8'hFF, 1'b0);
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'hA3;
    run_frame(8'hA3, 1'b0);
    next_cycle();
    have_next_i = 1'b0;
    #1;
    chk("post_a3_busy", busy_o, 1'b0);
    chk("post_a3_no_pop", next_o, 1'b0);

    // FIFO inputs toggling during a frame are ignored.
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'h6B;
    run_frame(8'h6B, 1'b1);
    next_cycle();
    have_next_i = 1'b0;
    #1;
    chk("post_scr_busy", busy_o, 1'b0);
    chk("post_scr_no_pop", next_o, 1'b0);

    // Reset for 2 cycles during data bit 3 of 0xC3 (bit 3 is 0).
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'hC3;
    #1;
    chk("c3_pop", next_o, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      next_cycle();
      have_next_i = 1'b0;
    end
    #1;
    chk("c3_bit3_tx", tx_o, 1'b0);
    chk("c3_bit3_busy", busy_o, 1'b1);
    next_cycle();
    reset_ni = 1'b0;
    have_next_i = 1'b1;
    #1;
    chk("midrst_no_pop1", next_o, 1'b0);
    next_cycle();
    #1;
    chk("midrst_no_pop2", next_o, 1'b0);
    chk("midrst_tx", tx_o, 1'b1);
    chk("midrst_busy", busy_o, 1'b0);
    next_cycle();
    reset_ni = 1'b1;
    have_next_i = 1'b1;
    data_i = 8'h5A;
    chk("rel_tx", tx_o, 1'b1);
    chk("rel_busy", busy_o, 1'b0);
    run_frame(8'h5A, 1'b0);
    next_cycle();
    have_next_i = 1'b0;
    #1;
    chk("post_5a_busy", busy_o, 1'b0);

    // 0x07 then 0x03 back to back (parity 1 then 0 when enabled).
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'h07;
    run_frame(8'h07, 1'b0);
    next_cycle();
    have_next_i = 1'b1;
    data_i = 8'h03;
    run_frame(8'h03, 1'b0);
    next_cycle();
    have_next_i = 1'b0;
    #1;
    chk("post_03_busy", busy_o, 1'b0);
    chk("post_03_tx", tx_o, 1'b1);
    chk("post_03_no_pop", next_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
